// File: rtl/bmem_responder.sv
// Burst-memory responder: 32-byte lines moved as four 64-bit beats, backed by internal storage.
// Reads are queued with an accept timestamp and returned in order once they are LATENCY cycles old.
module bmem_responder #(
  parameter int unsigned LINE_IDX_W = 8,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
);

  localparam int unsigned BEAT_W = 2;
  localparam int unsigned MEM_AW = LINE_IDX_W + BEAT_W;
  localparam int unsigned TAG_W  = 27;
  localparam int unsigned TS_W   = 8;
  localparam int unsigned QPTR_W = $clog2(QDEPTH);
  localparam int unsigned QCNT_W = QPTR_W + 1;

  typedef enum logic {W_IDLE, W_BEAT} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;

  logic [63:0] mem [0:(1<<MEM_AW)-1];

  logic [LINE_IDX_W-1:0] req_line;
  logic                  unused_addr_lsbs;

  assign req_line         = bmem_addr[5 +: LINE_IDX_W];
  assign unused_addr_lsbs = ^bmem_addr[4:0];

  // ---------------- write path ----------------
  w_state_e              w_state, w_state_nxt;
  logic [BEAT_W-1:0]     w_beat;
  logic [LINE_IDX_W-1:0] w_line;
  logic                  wr_busy_nxt;
  logic                  accept_wr, accept_rd;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_beat  <= '0;
      w_line  <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (accept_wr) begin
        w_beat <= BEAT_W'(1);
        w_line <= req_line;
      end else if (w_state == W_BEAT && bmem_write) begin
        w_beat <= w_beat + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (accept_wr) w_state_nxt = W_BEAT;
      W_BEAT:  if (bmem_write && w_beat == BEAT_W'(3)) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write beats after the first are not gated by ready; a read alongside a new write is dropped.
  always_comb begin
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = {req_line, BEAT_W'(0)};
    case (w_state)
      W_IDLE: begin
        accept_wr = bmem_write & bmem_ready;
        accept_rd = bmem_read & ~bmem_write & bmem_ready;
        mem_we    = accept_wr;
      end
      W_BEAT: begin
        mem_we    = bmem_write;
        mem_waddr = {w_line, w_beat};
      end
      default: ;
    endcase
  end

  assign wr_busy_nxt = (w_state_nxt == W_BEAT);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bmem_wdata;
  end

  // ---------------- read queue ----------------
  logic [TAG_W-1:0]  q_tag [QDEPTH];
  logic [TS_W-1:0]   q_ts  [QDEPTH];
  logic [QPTR_W-1:0] q_wr_ptr, q_rd_ptr;
  logic [QCNT_W-1:0] q_count, q_count_nxt;
  logic [TS_W-1:0]   ts_now, head_age;
  logic [TAG_W-1:0]  head_tag;
  logic              head_ready;
  logic              ready_nxt;

  always_ff @(posedge clk) begin
    if (accept_rd) begin
      q_tag[q_wr_ptr] <= bmem_addr[31:5];
      q_ts[q_wr_ptr]  <= ts_now;
    end
  end

  // Age is modular so the free-running timestamp may wrap freely.
  assign head_tag   = q_tag[q_rd_ptr];
  assign head_age   = ts_now - q_ts[q_rd_ptr];
  assign head_ready = (q_count != '0) && (head_age >= TS_W'(LATENCY));

  // ---------------- read FSM ----------------
  r_state_e          r_state, r_state_nxt;
  logic [BEAT_W-1:0] r_beat, r_beat_nxt;
  logic              emit, pop;
  logic [BEAT_W-1:0] emit_beat;

  always_comb begin
    r_state_nxt = r_state;
    r_beat_nxt  = r_beat;
    case (r_state)
      R_IDLE: begin
        if (head_ready) begin
          r_state_nxt = R_BURST;
          r_beat_nxt  = BEAT_W'(1);
        end
      end
      R_BURST: begin
        r_beat_nxt = r_beat + BEAT_W'(1);
        if (r_beat == BEAT_W'(3)) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Beat 0 leaves on the edge the head becomes eligible; beats 1..3 follow from R_BURST.
  always_comb begin
    emit      = 1'b0;
    emit_beat = '0;
    case (r_state)
      R_IDLE:  emit = head_ready;
      R_BURST: begin
        emit      = 1'b1;
        emit_beat = r_beat;
      end
      default: ;
    endcase
    pop = emit && (emit_beat == BEAT_W'(3));
  end

  assign q_count_nxt = q_count + QCNT_W'(accept_rd) - QCNT_W'(pop);
  assign ready_nxt   = wr_busy_nxt | (q_count_nxt < QCNT_W'(QDEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= R_IDLE;
      r_beat      <= '0;
      q_wr_ptr    <= '0;
      q_rd_ptr    <= '0;
      q_count     <= '0;
      ts_now      <= '0;
      bmem_ready  <= 1'b0;
      bmem_rvalid <= 1'b0;
      bmem_raddr  <= '0;
      bmem_rdata  <= '0;
    end else begin
      r_state     <= r_state_nxt;
      r_beat      <= r_beat_nxt;
      ts_now      <= ts_now + TS_W'(1);
      q_count     <= q_count_nxt;
      if (accept_rd) q_wr_ptr <= q_wr_ptr + QPTR_W'(1);
      if (pop)       q_rd_ptr <= q_rd_ptr + QPTR_W'(1);
      bmem_ready  <= ready_nxt;
      bmem_rvalid <= emit;
      if (emit) begin
        bmem_raddr <= {head_tag, 5'b0};
        bmem_rdata <= mem[{head_tag[LINE_IDX_W-1:0], emit_beat}];
      end
    end
  end

endmodule
